// File: rtl/huc_pkg.sv
// Shared types and widths for the HuC6280 block-transfer sequencer.
package huc_pkg;

    localparam int unsigned ADDR_W_DEF = 16;
    localparam int unsigned LEN_W_DEF  = 16;
    localparam int unsigned DATA_W     = 8;
    localparam int unsigned MODE_W     = 3;

    typedef enum logic [MODE_W-1:0] {
        TII = 3'd0,
        TDD = 3'd1,
        TIN = 3'd2,
        TIA = 3'd3,
        TAI = 3'd4
    } xfer_mode_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } xfer_state_t;

    // Unused encodings 5-7 behave as TII.
    function automatic xfer_mode_t decode_mode(input logic [MODE_W-1:0] raw);
        xfer_mode_t m;
        case (raw)
            3'd1:    m = TDD;
            3'd2:    m = TIN;
            3'd3:    m = TIA;
            3'd4:    m = TAI;
            default: m = TII;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/blk_xfer_seq_if.sv
// Virtual-bus bundle between the CPU/MMU side and the block-transfer sequencer.
interface blk_xfer_seq_if
    import huc_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned LEN_W  = LEN_W_DEF
);

    logic              start;
    logic [MODE_W-1:0] mode;
    logic [ADDR_W-1:0] src;
    logic [ADDR_W-1:0] dst;
    logic [LEN_W-1:0]  len;
    logic [DATA_W-1:0] d_in;
    logic [ADDR_W-1:0] vaddr;
    logic              rd_en;
    logic              wr_en;
    logic [DATA_W-1:0] d_out;
    logic              busy;
    logic              done;

    modport master (
        output start, mode, src, dst, len, d_in,
        input  vaddr, rd_en, wr_en, d_out, busy, done
    );

    modport slave (
        input  start, mode, src, dst, len, d_in,
        output vaddr, rd_en, wr_en, d_out, busy, done
    );

endinterface

// File: rtl/blk_addr_step.sv
// Per-mode address stepping: next source/destination plus the effective
// write address of this transfer and the effective read address of the next one.
module blk_addr_step
    import huc_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF
)
(
    input  xfer_mode_t        mode,
    input  logic [ADDR_W-1:0] src_cur,
    input  logic [ADDR_W-1:0] dst_cur,
    input  logic              toggle,
    output logic [ADDR_W-1:0] src_nxt,
    output logic [ADDR_W-1:0] dst_nxt,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [ADDR_W-1:0] rd_addr_nxt
);

    localparam logic [ADDR_W-1:0] ONE = ADDR_W'(1);

    logic              toggle_inv;
    logic [ADDR_W-1:0] tog_cur;
    logic [ADDR_W-1:0] tog_nxt;

    always_comb begin
        toggle_inv = ~toggle;
        tog_cur    = {{(ADDR_W-1){1'b0}}, toggle};
        tog_nxt    = {{(ADDR_W-1){1'b0}}, toggle_inv};
        src_nxt    = src_cur;
        dst_nxt    = dst_cur;

        case (mode)
            TII: begin
                src_nxt = src_cur + ONE;
                dst_nxt = dst_cur + ONE;
            end
            TDD: begin
                src_nxt = src_cur - ONE;
                dst_nxt = dst_cur - ONE;
            end
            TIN, TIA: begin
                src_nxt = src_cur + ONE;
            end
            TAI: begin
                dst_nxt = dst_cur + ONE;
            end
            default: begin
                src_nxt = src_cur + ONE;
                dst_nxt = dst_cur + ONE;
            end
        endcase

        // Alternating 0/+1 offset rides on the fixed side of TIA/TAI.
        wr_addr     = dst_cur + ((mode == TIA) ? tog_cur : '0);
        rd_addr_nxt = src_nxt + ((mode == TAI) ? tog_nxt : '0);
    end

endmodule

// File: rtl/blk_xfer_seq.sv
// HuC6280 block-transfer sequencer: owns the virtual bus once started and
// issues alternating read/write cycles until the length count runs out.
module blk_xfer_seq
    import huc_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned LEN_W  = LEN_W_DEF
)
(
    input  logic clk,
    input  logic reset,
    input  logic RDY,
    blk_xfer_seq_if.slave bus
);

    xfer_state_t       state_q, state_d;
    xfer_mode_t        mode_q, mode_d;
    logic [ADDR_W-1:0] src_q, src_d;
    logic [ADDR_W-1:0] dst_q, dst_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic              toggle_q, toggle_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [ADDR_W-1:0] vaddr_q, vaddr_d;
    logic              rd_en_q, rd_en_d;
    logic              wr_en_q, wr_en_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic [ADDR_W-1:0] src_nxt;
    logic [ADDR_W-1:0] dst_nxt;
    logic [ADDR_W-1:0] wr_addr;
    logic [ADDR_W-1:0] rd_addr_nxt;

    blk_addr_step #(
        .ADDR_W (ADDR_W)
    ) u_step (
        .mode        (mode_q),
        .src_cur     (src_q),
        .dst_cur     (dst_q),
        .toggle      (toggle_q),
        .src_nxt     (src_nxt),
        .dst_nxt     (dst_nxt),
        .wr_addr     (wr_addr),
        .rd_addr_nxt (rd_addr_nxt)
    );

    // State register; RDY low freezes everything, reset overrides the freeze.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else if (RDY) begin
            state_q <= state_d;
        end
    end

    // Datapath and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            mode_q   <= TII;
            src_q    <= '0;
            dst_q    <= '0;
            len_q    <= '0;
            toggle_q <= 1'b0;
            data_q   <= '0;
            vaddr_q  <= '0;
            rd_en_q  <= 1'b0;
            wr_en_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else if (RDY) begin
            mode_q   <= mode_d;
            src_q    <= src_d;
            dst_q    <= dst_d;
            len_q    <= len_d;
            toggle_q <= toggle_d;
            data_q   <= data_d;
            vaddr_q  <= vaddr_d;
            rd_en_q  <= rd_en_d;
            wr_en_q  <= wr_en_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    // Next state, and the bus outputs for the cycle that state will occupy.
    always_comb begin
        state_d  = state_q;
        mode_d   = mode_q;
        src_d    = src_q;
        dst_d    = dst_q;
        len_d    = len_q;
        toggle_d = toggle_q;
        data_d   = data_q;
        vaddr_d  = vaddr_q;
        rd_en_d  = 1'b0;
        wr_en_d  = 1'b0;
        busy_d   = 1'b0;
        done_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d  = READ;
                    mode_d   = decode_mode(bus.mode);
                    src_d    = bus.src;
                    dst_d    = bus.dst;
                    len_d    = bus.len;
                    toggle_d = 1'b0;
                    vaddr_d  = bus.src;
                    rd_en_d  = 1'b1;
                    busy_d   = 1'b1;
                end
            end
            READ: begin
                state_d = WRITE;
                data_d  = bus.d_in;
                vaddr_d = wr_addr;
                wr_en_d = 1'b1;
                busy_d  = 1'b1;
            end
            WRITE: begin
                src_d    = src_nxt;
                dst_d    = dst_nxt;
                len_d    = len_q - LEN_W'(1);
                toggle_d = ~toggle_q;
                busy_d   = 1'b1;
                // A loaded count of 0 wraps and runs the full 2^LEN_W transfers.
                if (len_q == LEN_W'(1)) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                end else begin
                    state_d = READ;
                    vaddr_d = rd_addr_nxt;
                    rd_en_d = 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.vaddr = vaddr_q;
    assign bus.rd_en = rd_en_q;
    assign bus.wr_en = wr_en_q;
    assign bus.d_out = data_q;
    assign bus.busy  = busy_q;
    assign bus.done  = done_q;

endmodule

// File: tb/tb_blk_xfer_seq.sv
// Self-checking bench for blk_xfer_seq against a per-transfer address/data model.
module tb_blk_xfer_seq;
    import huc_pkg::*;

    logic clk;
    logic reset;
    logic rdy;
    logic rdy_s;

    int n_checks = 0;
    int n_fail   = 0;

    logic [15:0] rd_addr_q[$];
    logic [7:0]  rd_data_q[$];
    logic [15:0] wr_addr_q[$];
    logic [7:0]  wr_data_q[$];

    blk_xfer_seq_if #(.ADDR_W(16), .LEN_W(16)) xif ();
    blk_xfer_seq_if #(.ADDR_W(16), .LEN_W(8))  xif_s ();

    blk_xfer_seq #(.ADDR_W(16), .LEN_W(16)) dut (
        .clk   (clk),
        .reset (reset),
        .RDY   (rdy),
        .bus   (xif.slave)
    );

    // Narrow length counter so the len=0 wrap case fits a short run.
    blk_xfer_seq #(.ADDR_W(16), .LEN_W(8)) dut_s (
        .clk   (clk),
        .reset (reset),
        .RDY   (rdy_s),
        .bus   (xif_s.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: address of the i-th read / write of a transfer.
    function automatic logic [15:0] exp_rd(input logic [2:0] m, input logic [15:0] s, input int i);
        case (m)
            3'd1:    return s - 16'(i);
            3'd4:    return s + 16'(i % 2);
            default: return s + 16'(i);
        endcase
    endfunction

    function automatic logic [15:0] exp_wr(input logic [2:0] m, input logic [15:0] d, input int i);
        case (m)
            3'd1:    return d - 16'(i);
            3'd2:    return d;
            3'd3:    return d + 16'(i % 2);
            default: return d + 16'(i);
        endcase
    endfunction

    // Drives one transfer on the main DUT and records the observed bus activity.
    task automatic run_xfer(input logic [2:0] m, input logic [15:0] s, input logic [15:0] d,
                            input logic [15:0] n, input int rdy_pct, input bit poke_start,
                            output int done_at, output int n_proto, output logic [3:0] post,
                            output bit timed_out);
        int act;
        int guard;
        bit rdy_n;
        rd_addr_q.delete(); rd_data_q.delete();
        wr_addr_q.delete(); wr_data_q.delete();
        done_at = -1; n_proto = 0; timed_out = 1'b0;
        @(negedge clk);
        xif.start = 1'b1; xif.mode = m; xif.src = s; xif.dst = d; xif.len = n; rdy = 1'b1;
        @(posedge clk);
        act = 1;
        @(negedge clk);
        xif.start = 1'b0;
        xif.src = 16'($urandom); xif.dst = 16'($urandom);
        xif.len = 16'($urandom); xif.mode = 3'($urandom);
        guard = 0;
        while (xif.done !== 1'b1 && guard < 4000) begin
            if ((xif.rd_en ^ xif.wr_en) !== 1'b1 || xif.busy !== 1'b1) n_proto++;
            rdy_n = ($urandom_range(99) < rdy_pct);
            rdy = rdy_n;
            xif.d_in = 8'($urandom);
            if (poke_start) xif.start = 1'($urandom_range(1));
            if (rdy_n && xif.rd_en === 1'b1) begin
                rd_addr_q.push_back(xif.vaddr);
                rd_data_q.push_back(xif.d_in);
            end
            if (rdy_n && xif.wr_en === 1'b1) begin
                wr_addr_q.push_back(xif.vaddr);
                wr_data_q.push_back(xif.d_out);
            end
            @(posedge clk);
            if (rdy_n) act++;
            @(negedge clk);
            guard++;
        end
        if (xif.done === 1'b1) begin
            done_at = act;
            if (xif.busy !== 1'b1 || xif.rd_en !== 1'b0 || xif.wr_en !== 1'b0) n_proto++;
        end else begin
            timed_out = 1'b1;
        end
        xif.start = 1'b0;
        rdy = 1'b1;
        @(posedge clk);
        @(negedge clk);
        post = {xif.busy, xif.done, xif.rd_en, xif.wr_en};
    endtask

    task automatic test_reset();
        reset = 1'b1; rdy = 1'b1; rdy_s = 1'b1;
        xif.start = 1'b0; xif.mode = '0; xif.src = '0; xif.dst = '0; xif.len = '0; xif.d_in = '0;
        xif_s.start = 1'b0; xif_s.mode = '0; xif_s.src = '0; xif_s.dst = '0; xif_s.len = '0; xif_s.d_in = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (xif.vaddr !== 16'h0000) begin n_fail++; $display("FAIL reset_vaddr got %h want 0000", xif.vaddr); end
        n_checks++;
        if (xif.d_out !== 8'h00) begin n_fail++; $display("FAIL reset_d_out got %h want 00", xif.d_out); end
        n_checks++;
        if ({xif.rd_en, xif.wr_en, xif.busy, xif.done} !== 4'b0000) begin
            n_fail++; $display("FAIL reset_ctrl got %b want 0000", {xif.rd_en, xif.wr_en, xif.busy, xif.done});
        end
        n_checks++;
        if ({xif_s.rd_en, xif_s.wr_en, xif_s.busy, xif_s.done} !== 4'b0000) begin
            n_fail++; $display("FAIL reset_ctrl_small got %b want 0000", {xif_s.rd_en, xif_s.wr_en, xif_s.busy, xif_s.done});
        end
        reset = 1'b0;
    endtask

    task automatic test_directed();
        logic [2:0]  t_mode [5] = '{3'd0, 3'd1, 3'd3, 3'd4, 3'd6};
        logic [15:0] t_src  [5] = '{16'h2000, 16'h0001, 16'h4000, 16'h0402, 16'hFFFE};
        logic [15:0] t_dst  [5] = '{16'h3000, 16'h0000, 16'h0402, 16'h5000, 16'h0010};
        logic [15:0] t_len  [5] = '{16'd3, 16'd2, 16'd4, 16'd3, 16'd3};
        int done_at; int n_proto; logic [3:0] post; bit timed_out; int n;
        for (int t = 0; t < 5; t++) begin
            run_xfer(t_mode[t], t_src[t], t_dst[t], t_len[t], 100, 1'b0, done_at, n_proto, post, timed_out);
            n = int'(t_len[t]);
            n_checks++;
            if (timed_out) begin n_fail++; $display("FAIL dir%0d_timeout done not seen, want done", t); end
            n_checks++;
            if (rd_addr_q.size() != n) begin n_fail++; $display("FAIL dir%0d_rd_count got %0d want %0d", t, rd_addr_q.size(), n); end
            n_checks++;
            if (wr_addr_q.size() != n) begin n_fail++; $display("FAIL dir%0d_wr_count got %0d want %0d", t, wr_addr_q.size(), n); end
            for (int i = 0; i < n && i < rd_addr_q.size(); i++) begin
                n_checks++;
                if (rd_addr_q[i] !== exp_rd(t_mode[t], t_src[t], i)) begin
                    n_fail++; $display("FAIL dir%0d_rd_addr[%0d] got %h want %h", t, i, rd_addr_q[i], exp_rd(t_mode[t], t_src[t], i));
                end
            end
            for (int i = 0; i < n && i < wr_addr_q.size(); i++) begin
                n_checks++;
                if (wr_addr_q[i] !== exp_wr(t_mode[t], t_dst[t], i)) begin
                    n_fail++; $display("FAIL dir%0d_wr_addr[%0d] got %h want %h", t, i, wr_addr_q[i], exp_wr(t_mode[t], t_dst[t], i));
                end
                if (i < rd_data_q.size()) begin
                    n_checks++;
                    if (wr_data_q[i] !== rd_data_q[i]) begin
                        n_fail++; $display("FAIL dir%0d_wr_data[%0d] got %h want %h", t, i, wr_data_q[i], rd_data_q[i]);
                    end
                end
            end
            n_checks++;
            if (done_at != 2 * n + 1) begin n_fail++; $display("FAIL dir%0d_done_cycle got %0d want %0d", t, done_at, 2 * n + 1); end
            n_checks++;
            if (n_proto != 0) begin n_fail++; $display("FAIL dir%0d_protocol got %0d bad cycles want 0", t, n_proto); end
            n_checks++;
            if (post !== 4'b0000) begin n_fail++; $display("FAIL dir%0d_post_idle got %b want 0000", t, post); end
        end
    endtask

    task automatic test_freeze();
        @(negedge clk);
        xif.start = 1'b1; xif.mode = 3'd0; xif.src = 16'h1234; xif.dst = 16'h8000; xif.len = 16'd2;
        xif.d_in = 8'hA5; rdy = 1'b1;
        @(posedge clk); @(negedge clk);
        xif.start = 1'b0;
        n_checks++;
        if ({xif.rd_en, xif.wr_en, xif.busy} !== 3'b101 || xif.vaddr !== 16'h1234) begin
            n_fail++; $display("FAIL frz_read1 got rd/wr/busy %b vaddr %h want 101 1234", {xif.rd_en, xif.wr_en, xif.busy}, xif.vaddr);
        end
        @(posedge clk); @(negedge clk);
        rdy = 1'b0; xif.start = 1'b1; xif.d_in = 8'h3C;
        for (int k = 0; k < 4; k++) begin
            n_checks++;
            if ({xif.rd_en, xif.wr_en, xif.busy} !== 3'b011 || xif.vaddr !== 16'h8000 || xif.d_out !== 8'hA5) begin
                n_fail++;
                $display("FAIL frz_hold[%0d] got rd/wr/busy %b vaddr %h d_out %h want 011 8000 a5",
                         k, {xif.rd_en, xif.wr_en, xif.busy}, xif.vaddr, xif.d_out);
            end
            if (k == 3) rdy = 1'b1;
            @(posedge clk); @(negedge clk);
        end
        xif.start = 1'b0;
        n_checks++;
        if ({xif.rd_en, xif.wr_en} !== 2'b10 || xif.vaddr !== 16'h1235) begin
            n_fail++; $display("FAIL frz_read2 got rd/wr %b vaddr %h want 10 1235", {xif.rd_en, xif.wr_en}, xif.vaddr);
        end
        @(posedge clk); @(negedge clk);
        n_checks++;
        if ({xif.rd_en, xif.wr_en} !== 2'b01 || xif.vaddr !== 16'h8001 || xif.d_out !== 8'h3C) begin
            n_fail++; $display("FAIL frz_write2 got rd/wr %b vaddr %h d_out %h want 01 8001 3c", {xif.rd_en, xif.wr_en}, xif.vaddr, xif.d_out);
        end
        @(posedge clk); @(negedge clk);
        n_checks++;
        if ({xif.rd_en, xif.wr_en, xif.busy, xif.done} !== 4'b0011) begin
            n_fail++; $display("FAIL frz_done got rd/wr/busy/done %b want 0011", {xif.rd_en, xif.wr_en, xif.busy, xif.done});
        end
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); @(negedge clk);
            n_checks++;
            if ({xif.rd_en, xif.wr_en, xif.busy, xif.done} !== 4'b0000) begin
                n_fail++; $display("FAIL frz_idle[%0d] got rd/wr/busy/done %b want 0000", k, {xif.rd_en, xif.wr_en, xif.busy, xif.done});
            end
        end
    endtask

    task automatic test_random();
        logic [2:0] m; logic [15:0] s; logic [15:0] d; int n;
        int done_at; int n_proto; logic [3:0] post; bit timed_out; int bad;
        for (int t = 0; t < 25; t++) begin
            m = 3'($urandom_range(7));
            case ($urandom_range(2))
                0:       s = 16'($urandom);
                1:       s = 16'hFFFF - 16'($urandom_range(3));
                default: s = 16'($urandom_range(3));
            endcase
            d = ($urandom_range(1) == 0) ? 16'($urandom) : 16'hFFFF - 16'($urandom_range(3));
            n = int'($urandom_range(6, 1));
            run_xfer(m, s, d, 16'(n), 65, 1'b1, done_at, n_proto, post, timed_out);
            bad = 0;
            for (int i = 0; i < n && i < rd_addr_q.size(); i++)
                if (rd_addr_q[i] !== exp_rd(m, s, i)) bad++;
            for (int i = 0; i < n && i < wr_addr_q.size() && i < rd_data_q.size(); i++)
                if (wr_addr_q[i] !== exp_wr(m, d, i) || wr_data_q[i] !== rd_data_q[i]) bad++;
            n_checks++;
            if (timed_out || rd_addr_q.size() != n || wr_addr_q.size() != n) begin
                n_fail++;
                $display("FAIL rnd%0d_counts mode %0d got rd %0d wr %0d timeout %0d want %0d %0d 0",
                         t, m, rd_addr_q.size(), wr_addr_q.size(), timed_out, n, n);
            end
            n_checks++;
            if (bad != 0) begin
                n_fail++; $display("FAIL rnd%0d_seq mode %0d src %h dst %h len %0d got %0d mismatches want 0", t, m, s, d, n, bad);
            end
            n_checks++;
            if (done_at != 2 * n + 1 || n_proto != 0 || post !== 4'b0000) begin
                n_fail++;
                $display("FAIL rnd%0d_timing got done %0d proto %0d post %b want %0d 0 0000", t, done_at, n_proto, post, 2 * n + 1);
            end
        end
    endtask

    task automatic test_len0();
        int act; int n_rd; int n_wr; int bad; int guard; bit last_wr;
        @(negedge clk);
        xif_s.start = 1'b1; xif_s.mode = 3'd2; xif_s.src = 16'hFFF0; xif_s.dst = 16'h7777; xif_s.len = 8'h00;
        rdy_s = 1'b1;
        @(posedge clk);
        act = 1;
        @(negedge clk);
        xif_s.start = 1'b0;
        n_rd = 0; n_wr = 0; bad = 0; guard = 0; last_wr = 1'b0;
        while (xif_s.done !== 1'b1 && guard < 3000) begin
            if (xif_s.rd_en === 1'b1) begin
                if (xif_s.vaddr !== 16'hFFF0 + 16'(n_rd)) bad++;
                n_rd++; last_wr = 1'b0;
            end
            if (xif_s.wr_en === 1'b1) begin
                if (xif_s.vaddr !== 16'h7777) bad++;
                n_wr++; last_wr = 1'b1;
            end
            xif_s.d_in = 8'($urandom);
            @(posedge clk); act++;
            @(negedge clk); guard++;
        end
        n_checks++;
        if (xif_s.done !== 1'b1) begin n_fail++; $display("FAIL len0_timeout done %b want 1", xif_s.done); end
        n_checks++;
        if (n_wr != 256 || n_rd != 256) begin n_fail++; $display("FAIL len0_count got rd %0d wr %0d want 256 256", n_rd, n_wr); end
        n_checks++;
        if (bad != 0) begin n_fail++; $display("FAIL len0_addr got %0d bad addresses want 0", bad); end
        n_checks++;
        if (!last_wr || act != 513) begin n_fail++; $display("FAIL len0_done got last_wr %0d cycle %0d want 1 513", last_wr, act); end
        @(posedge clk); @(negedge clk);
        n_checks++;
        if ({xif_s.busy, xif_s.done} !== 2'b00) begin n_fail++; $display("FAIL len0_idle got busy/done %b want 00", {xif_s.busy, xif_s.done}); end
    endtask

    task automatic test_reset_abort();
        @(negedge clk);
        xif.start = 1'b1; xif.mode = 3'd0; xif.src = 16'h0100; xif.dst = 16'h0200; xif.len = 16'd10; rdy = 1'b1;
        @(posedge clk); @(negedge clk);
        xif.start = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (xif.busy !== 1'b1) begin n_fail++; $display("FAIL abort_pre_busy got %b want 1", xif.busy); end
        reset = 1'b1;
        @(posedge clk); @(negedge clk);
        reset = 1'b0;
        n_checks++;
        if ({xif.rd_en, xif.wr_en, xif.busy, xif.done} !== 4'b0000 || xif.vaddr !== 16'h0000) begin
            n_fail++; $display("FAIL abort_state got rd/wr/busy/done %b vaddr %h want 0000 0000",
                               {xif.rd_en, xif.wr_en, xif.busy, xif.done}, xif.vaddr);
        end
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); @(negedge clk);
            n_checks++;
            if ({xif.rd_en, xif.wr_en, xif.busy, xif.done} !== 4'b0000) begin
                n_fail++; $display("FAIL abort_quiet[%0d] got rd/wr/busy/done %b want 0000", k, {xif.rd_en, xif.wr_en, xif.busy, xif.done});
            end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_freeze();
        test_random();
        test_len0();
        test_reset_abort();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
